// File: rtl/obstacle_drawer.sv
`default_nettype none
// =============================================================================
// Module : obstacle_drawer
// Erases the previous obstacle rectangle, then draws the new one, one pixel
// per clock into the VGA adapter plot port.
// Rev    : 1.0
// =============================================================================
module obstacle_drawer #(
    parameter int         OBS_W     = 4,
    parameter int         BAND_H    = 8,
    parameter int         Y_TOP     = 72,
    parameter int         SCREEN_W  = 160,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       update,
    input  logic [7:0] x,
    input  logic [1:0] top_shape,
    input  logic [1:0] mid_shape,
    input  logic [1:0] bottom_shape,
    output logic       plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] colour,
    output logic       busy,
    output logic       done
);

    localparam int ROWS  = 3 * BAND_H;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (OBS_W > 1) ? $clog2(OBS_W) : 1;

    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(OBS_W - 1);
    localparam logic [ROW_W-1:0] c_BAND1    = ROW_W'(BAND_H);
    localparam logic [ROW_W-1:0] c_BAND2    = ROW_W'(2 * BAND_H);
    localparam logic [8:0]       c_SCREEN_W = 9'(SCREEN_W);
    localparam logic [6:0]       c_Y_TOP    = 7'(Y_TOP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_next_row;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_next_col;

    logic       r_update_d;
    logic       r_pending;
    logic       r_prev_valid;
    logic [7:0] r_prev_x;
    logic [7:0] r_cur_x;
    logic [1:0] r_cur_top;
    logic [1:0] r_cur_mid;
    logic [1:0] r_cur_bot;

    logic       w_edge;
    logic       w_start;
    logic       w_active;
    logic [7:0] w_cur_x;
    logic [1:0] w_cur_top;
    logic [1:0] w_cur_mid;
    logic [1:0] w_cur_bot;
    logic [7:0] w_base;
    logic [8:0] w_px;
    logic [1:0] w_shape;
    logic [2:0] w_draw_colour;
    logic       w_plot_n;
    logic [6:0] w_vga_y_n;
    logic [2:0] w_colour_n;

    // Next-state logic and the pixel that will be presented in the next cycle.
    always_comb begin
        w_edge       = update & ~r_update_d;
        w_start      = (r_state == S_IDLE) && (w_edge || r_pending);
        w_next_state = r_state;
        w_next_row   = r_row;
        w_next_col   = r_col;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = r_prev_valid ? S_ERASE : S_DRAW;
                    w_next_row   = '0;
                    w_next_col   = '0;
                end
            end
            S_ERASE, S_DRAW: begin
                if (r_col == c_COL_LAST) begin
                    w_next_col = '0;
                    if (r_row == c_ROW_LAST) begin
                        w_next_row   = '0;
                        w_next_state = (r_state == S_ERASE) ? S_DRAW : S_DONE;
                    end else begin
                        w_next_row = r_row + 1'b1;
                    end
                end else begin
                    w_next_col = r_col + 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        // The first pixel of a frame must use the inputs being latched this cycle.
        w_cur_x   = w_start ? x            : r_cur_x;
        w_cur_top = w_start ? top_shape    : r_cur_top;
        w_cur_mid = w_start ? mid_shape    : r_cur_mid;
        w_cur_bot = w_start ? bottom_shape : r_cur_bot;

        w_active = (w_next_state == S_ERASE) || (w_next_state == S_DRAW);
        w_base   = (w_next_state == S_ERASE) ? r_prev_x : w_cur_x;
        w_px     = {1'b0, w_base} + 9'(w_next_col);
        w_plot_n = w_active && (w_px < c_SCREEN_W);

        if (w_next_row < c_BAND1) begin
            w_shape = w_cur_top;
        end else if (w_next_row < c_BAND2) begin
            w_shape = w_cur_mid;
        end else begin
            w_shape = w_cur_bot;
        end

        case (w_shape)
            2'b01:   w_draw_colour = 3'b100;
            2'b10:   w_draw_colour = 3'b010;
            2'b11:   w_draw_colour = 3'b001;
            default: w_draw_colour = BG_COLOUR;
        endcase

        w_vga_y_n  = w_active ? (c_Y_TOP + 7'(w_next_row)) : 7'd0;
        if (!w_active) begin
            w_colour_n = 3'b000;
        end else if (w_next_state == S_ERASE) begin
            w_colour_n = BG_COLOUR;
        end else begin
            w_colour_n = w_draw_colour;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_update_d   <= 1'b0;
            r_pending    <= 1'b0;
            r_prev_valid <= 1'b0;
            r_prev_x     <= '0;
            r_cur_x      <= '0;
            r_cur_top    <= '0;
            r_cur_mid    <= '0;
            r_cur_bot    <= '0;
            plot         <= 1'b0;
            vga_x        <= '0;
            vga_y        <= '0;
            colour       <= '0;
        end else begin
            r_state    <= w_next_state;
            r_row      <= w_next_row;
            r_col      <= w_next_col;
            r_update_d <= update;

            if (w_start) begin
                r_pending <= 1'b0;
                r_cur_x   <= x;
                r_cur_top <= top_shape;
                r_cur_mid <= mid_shape;
                r_cur_bot <= bottom_shape;
            end else if (w_edge && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            if (r_state == S_DONE) begin
                r_prev_x     <= r_cur_x;
                r_prev_valid <= 1'b1;
            end

            plot   <= w_plot_n;
            vga_x  <= w_active ? w_px[7:0] : 8'd0;
            vga_y  <= w_vga_y_n;
            colour <= w_colour_n;
        end
    end

    assign busy = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_obstacle_drawer.sv
`default_nettype none
// =============================================================================
// Module : tb_obstacle_drawer
// Frame-level checks of obstacle_drawer against a pixel-list reference model.
// Rev    : 1.0
// =============================================================================
module tb_obstacle_drawer;

    localparam int OBS_W    = 4;
    localparam int BAND_H   = 8;
    localparam int Y_TOP    = 72;
    localparam int SCREEN_W = 160;
    localparam int NPIX     = 3 * BAND_H * OBS_W;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       update = 1'b0;
    logic [7:0] x = '0;
    logic [1:0] top_shape = '0;
    logic [1:0] mid_shape = '0;
    logic [1:0] bottom_shape = '0;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_pass   = 0;
    int m_prev_x = 0;
    bit m_prev_valid = 1'b0;

    obstacle_drawer dut (
        .clk          (clk),
        .resetn       (resetn),
        .update       (update),
        .x            (x),
        .top_shape    (top_shape),
        .mid_shape    (mid_shape),
        .bottom_shape (bottom_shape),
        .plot         (plot),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .colour       (colour),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] code_colour(input logic [1:0] c);
        case (c)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Entered on the negedge where pixel 0 of the frame is visible; returns on
    // the negedge of the idle cycle after the done pulse.
    task automatic frame_body(input logic [7:0] fx, input logic [1:0] ft, fm, fb,
                              input bit scramble, input bit inject, output int draw_plots);
        int nph = m_prev_valid ? 2 : 1;
        int n = 0;
        draw_plots = 0;
        for (int ph = 0; ph < nph; ph++) begin
            bit er = (nph == 2) && (ph == 0);
            int base = er ? m_prev_x : int'(fx);
            for (int i = 0; i < NPIX; i++) begin
                int row = i / OBS_W;
                int px = base + (i % OBS_W);
                int band = row / BAND_H;
                bit ep = (px < SCREEN_W);
                logic [7:0] ex = px[7:0];
                logic [6:0] ey = 7'(Y_TOP + row);
                logic [2:0] ec = er ? 3'b000 :
                                 code_colour(band == 0 ? ft : (band == 1 ? fm : fb));
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0 || plot !== ep)
                    $display("FAIL frame_ctrl pix %0d er=%0d: busy=%b done=%b plot=%b, need busy=1 done=0 plot=%b",
                             i, er, busy, done, plot, ep);
                else n_pass++;
                if (ep) begin
                    n_checks++;
                    if (vga_x !== ex || vga_y !== ey || colour !== ec)
                        $display("FAIL frame_pixel pix %0d er=%0d: got x=%0d y=%0d c=%b, need x=%0d y=%0d c=%b",
                                 i, er, vga_x, vga_y, colour, ex, ey, ec);
                    else n_pass++;
                end
                if (!er && plot === 1'b1) draw_plots++;
                if (scramble) begin
                    x = 8'($urandom_range(0, 255));
                    top_shape = 2'($urandom); mid_shape = 2'($urandom); bottom_shape = 2'($urandom);
                end
                if (inject) update = (n == 10 || n == 50);
                n++;
                @(negedge clk);
            end
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || plot !== 1'b0)
            $display("FAIL done_pulse: done=%b busy=%b plot=%b, need 1 0 0", done, busy, plot);
        else n_pass++;
        m_prev_x = int'(fx);
        m_prev_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || plot !== 1'b0)
            $display("FAIL idle_after_done: done=%b busy=%b plot=%b, need 0 0 0", done, busy, plot);
        else n_pass++;
    endtask

    task automatic start_edge(input logic [7:0] fx, input logic [1:0] ft, fm, fb);
        @(negedge clk);
        x = fx; top_shape = ft; mid_shape = fm; bottom_shape = fb;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] fx, input logic [1:0] ft, fm, fb,
                            input bit scramble, output int draw_plots);
        start_edge(fx, ft, fm, fb);
        frame_body(fx, ft, fm, fb, scramble, 1'b0, draw_plots);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({plot, vga_x, vga_y, colour, busy, done} !== '0)
            $display("FAIL reset_outputs: plot=%b x=%0d y=%0d c=%b busy=%b done=%b, need all 0",
                     plot, vga_x, vga_y, colour, busy, done);
        else n_pass++;
        resetn = 1'b1;
        m_prev_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_first_and_second();
        int dp;
        do_frame(8'd156, 2'b00, 2'b11, 2'b01, 1'b0, dp);
        do_frame(8'd152, 2'b10, 2'b01, 2'b11, 1'b0, dp);
    endtask

    task automatic test_clip();
        int dp;
        do_frame(8'd158, 2'b11, 2'b11, 2'b11, 1'b0, dp);
        n_checks++;
        if (dp != 48) $display("FAIL clip_count: draw plots=%0d, need 48", dp);
        else n_pass++;
    endtask

    task automatic test_random();
        int dp;
        for (int k = 0; k < 6; k++) begin
            logic [7:0] rx = 8'($urandom_range(0, 156));
            do_frame(rx, 2'($urandom), 2'($urandom), 2'($urandom), k[0], dp);
        end
    endtask

    task automatic test_pending();
        int dp;
        logic [7:0] ax = 8'($urandom_range(0, 156));
        logic [7:0] bx = 8'($urandom_range(0, 156));
        logic [1:0] bt = 2'($urandom), bm = 2'($urandom), bb = 2'($urandom);
        start_edge(ax, 2'b01, 2'b10, 2'b11);
        frame_body(ax, 2'b01, 2'b10, 2'b11, 1'b0, 1'b1, dp);
        x = bx; top_shape = bt; mid_shape = bm; bottom_shape = bb;
        @(negedge clk);
        frame_body(bx, bt, bm, bb, 1'b0, 1'b0, dp);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0)
                $display("FAIL no_third_frame cyc %0d: busy=%b done=%b, need 0 0", i, busy, done);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int dp;
        start_edge(8'd40, 2'b11, 2'b01, 2'b10);
        repeat (NPIX + 20) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({plot, vga_x, vga_y, colour, busy, done} !== '0)
            $display("FAIL async_reset: plot=%b x=%0d y=%0d c=%b busy=%b done=%b, need all 0",
                     plot, vga_x, vga_y, colour, busy, done);
        else n_pass++;
        m_prev_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_frame(8'd100, 2'b10, 2'b10, 2'b01, 1'b0, dp);
    endtask

    initial begin
        test_reset();
        test_first_and_second();
        test_clip();
        test_random();
        test_pending();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
